// File: rtl/secuenciador_isa.sv
// rtl/secuenciador_isa.sv - multi-cycle fetch/decode/execute sequencer for the 20-bit datapath
// Optional single-step gating with `define SECUENCIADOR_PASO_EN (adds input paso).
module secuenciador_isa #(
  parameter int          PC_W      = 5,
  parameter logic [19:0] HALT_WORD = 20'hFFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
`ifdef SECUENCIADOR_PASO_EN
  input  logic            paso,
`endif
  input  logic [PC_W:0]   num_instr,
  output logic [PC_W-1:0] imem_addr,
  input  logic [19:0]     imem_data,
  output logic [19:0]     instruccion,
  output logic            busy,
  output logic            done,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0]   ejecutadas
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [19:0]   instr_q;
  logic [PC_W:0] num_q;
  logic [PC_W:0] pc_inc;
  logic          advance;
  logic          wr_en;
  logic          is_halt;

`ifdef SECUENCIADOR_PASO_EN
  assign advance = paso;
`else
  assign advance = 1'b1;
`endif

  assign pc_inc  = {1'b0, pc} + {{PC_W{1'b0}}, 1'b1};
  assign is_halt = (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_instr == '0) ? S_DONE : S_FETCH;
      S_FETCH:  state_d = abort ? S_DONE : S_DECODE;
      S_DECODE: begin
        if (abort || is_halt) state_d = S_DONE;
        else if (advance)     state_d = S_EXEC;
      end
      S_EXEC:   state_d = (abort || pc_inc == num_q) ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Write strobes exist only in a non-aborted EXEC cycle; read fields always come from instr_q.
  always_comb begin
    wr_en       = (state_q == S_EXEC) && !abort;
    busy        = (state_q != S_IDLE);
    imem_addr   = pc;
    instruccion = {instr_q[19:10], instr_q[9] & wr_en, instr_q[8:1], instr_q[0] & wr_en};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      ejecutadas <= '0;
      halted     <= 1'b0;
      done       <= 1'b0;
      instr_q    <= '0;
      num_q      <= '0;
    end else begin
      done <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q      <= num_instr;
            pc         <= '0;
            ejecutadas <= '0;
            halted     <= 1'b0;
          end
        end
        S_DECODE: begin
          if (!abort) begin
            if (is_halt) halted  <= 1'b1;
            else         instr_q <= imem_data;
          end
        end
        S_EXEC: begin
          // pc parks on the last address instead of wrapping when the run completes
          if (!abort) begin
            ejecutadas <= ejecutadas + {{PC_W{1'b0}}, 1'b1};
            if (pc_inc != num_q) pc <= pc_inc[PC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_isa.sv
// tb/tb_secuenciador_isa.sv - directed self-checking bench for secuenciador_isa
module tb_secuenciador_isa;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        paso;
  logic [5:0]  num_instr;
  logic [4:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] instruccion;
  logic        busy, done, halted;
  logic [4:0]  pc;
  logic [5:0]  ejecutadas;
  logic [19:0] rom [32];
  int          checks = 0;
  int          passed = 0;

  secuenciador_isa dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
`ifdef SECUENCIADOR_PASO_EN
    .paso       (paso),
`endif
    .num_instr  (num_instr),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instruccion(instruccion),
    .busy       (busy),
    .done       (done),
    .halted     (halted),
    .pc         (pc),
    .ejecutadas (ejecutadas)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= rom[imem_addr];

  task automatic launch(input logic [5:0] n);
    num_instr = n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, halted, pc, ejecutadas, instruccion, imem_addr} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b halted=%b pc=%0d ej=%0d instr=%h addr=%0d exp all 0",
               busy, done, halted, pc, ejecutadas, instruccion, imem_addr);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_program;
    int dcyc = -1;
    int dcnt = 0;
    int wbad = 0;
    rom[0] = 20'h0A2C3; rom[1] = 20'h11045; rom[2] = 20'h08040;
    launch(6'd3);
    for (int k = 1; k <= 13; k++) begin
      if (k == 3 || k == 6 || k == 9) begin
        checks++;
        if (instruccion !== rom[k/3-1])
          $display("FAIL prog_exec k=%0d got %h exp %h", k, instruccion, rom[k/3-1]);
        else passed++;
      end else if (instruccion[9] !== 1'b0 || instruccion[0] !== 1'b0) wbad++;
      if (k == 6) begin
        checks++;
        if (pc !== 5'd1) $display("FAIL prog_pc got %0d exp 1", pc); else passed++;
      end
      if (done) begin dcnt++; if (dcyc < 0) dcyc = k; end
      @(negedge clk);
    end
    checks++;
    if (wbad != 0) $display("FAIL prog_wbits_outside_exec got %0d exp 0", wbad); else passed++;
    checks++;
    if (dcyc != 11 || dcnt != 1) $display("FAIL prog_done got cycle=%0d count=%0d exp 11/1", dcyc, dcnt); else passed++;
    checks++;
    if (ejecutadas !== 6'd3 || halted !== 1'b0 || busy !== 1'b0)
      $display("FAIL prog_final got ej=%0d halted=%b busy=%b exp 3/0/0", ejecutadas, halted, busy);
    else passed++;
  endtask

  task automatic test_halt;
    int dcyc = -1;
    int wbad = 0;
    rom[0] = 20'h08040; rom[1] = 20'hFFFFF;
    launch(6'd5);
    for (int k = 1; k <= 10; k++) begin
      if (instruccion[9] !== 1'b0 || instruccion[0] !== 1'b0) wbad++;
      if (k == 3) begin
        checks++;
        if (instruccion !== 20'h08040) $display("FAIL halt_exec got %h exp 08040", instruccion); else passed++;
      end
      if (done && dcyc < 0) dcyc = k;
      @(negedge clk);
    end
    checks++;
    if (wbad != 0) $display("FAIL halt_wbits got %0d exp 0", wbad); else passed++;
    checks++;
    if (dcyc != 7) $display("FAIL halt_done_cycle got %0d exp 7", dcyc); else passed++;
    checks++;
    if (halted !== 1'b1 || ejecutadas !== 6'd1)
      $display("FAIL halt_final got halted=%b ej=%0d exp 1/1", halted, ejecutadas);
    else passed++;
  endtask

  task automatic test_zero_len;
    int dcyc = -1;
    int bcnt = 0;
    launch(6'd0);
    for (int k = 1; k <= 5; k++) begin
      if (busy) bcnt++;
      if (done && dcyc < 0) dcyc = k;
      @(negedge clk);
    end
    checks++;
    if (bcnt != 1 || dcyc != 2) $display("FAIL zero_len got busy_cycles=%0d done_cycle=%0d exp 1/2", bcnt, dcyc); else passed++;
    checks++;
    if (halted !== 1'b0 || ejecutadas !== 6'd0)
      $display("FAIL zero_len_clear got halted=%b ej=%0d exp 0/0", halted, ejecutadas);
    else passed++;
  endtask

  task automatic test_abort;
    rom[0] = 20'h0A2C3; rom[1] = 20'h11045; rom[2] = 20'h00201; rom[3] = 20'h08040;
    launch(6'd4);
    for (int k = 1; k < 9; k++) begin
      if (k == 3) begin
        checks++;
        if (instruccion !== 20'h0A2C3) $display("FAIL abort_exec0 got %h exp 0A2C3", instruccion); else passed++;
      end
      if (k == 4) begin start = 1'b1; num_instr = 6'd1; end
      if (k == 5) begin start = 1'b0; num_instr = 6'd4; end
      @(negedge clk);
    end
    checks++;
    if (pc !== 5'd2) $display("FAIL abort_pc_before got %0d exp 2", pc); else passed++;
    abort = 1'b1;
    #1;
    checks++;
    if (instruccion[9] !== 1'b0 || instruccion[0] !== 1'b0 || instruccion[19:10] !== rom[2][19:10])
      $display("FAIL abort_suppress got %h exp %h", instruccion, {rom[2][19:10], 10'h000});
    else passed++;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (ejecutadas !== 6'd2 || pc !== 5'd2 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL abort_after got ej=%0d pc=%0d busy=%b done=%b exp 2/2/1/0", ejecutadas, pc, busy, done);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) $display("FAIL abort_done got %b exp 1", done); else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_idle got busy=%b done=%b exp 0/0", busy, done); else passed++;
  endtask

  task automatic test_reset_midrun;
    int dcyc = -1;
    rom[0] = 20'h0A2C3; rom[1] = 20'h11045; rom[2] = 20'h08040;
    launch(6'd3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, halted, pc, ejecutadas, instruccion, imem_addr} !== '0)
      $display("FAIL reset_midrun got busy=%b done=%b halted=%b pc=%0d ej=%0d instr=%h exp all 0",
               busy, done, halted, pc, ejecutadas, instruccion);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    launch(6'd1);
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin
        checks++;
        if (instruccion !== 20'h0A2C3 || pc !== 5'd0)
          $display("FAIL rerun_exec got instr=%h pc=%0d exp 0A2C3/0", instruccion, pc);
        else passed++;
      end
      if (done && dcyc < 0) dcyc = k;
      @(negedge clk);
    end
    checks++;
    if (dcyc != 5 || ejecutadas !== 6'd1) $display("FAIL rerun_done got cycle=%0d ej=%0d exp 5/1", dcyc, ejecutadas); else passed++;
  endtask

`ifdef SECUENCIADOR_PASO_EN
  task automatic test_paso;
    int bad = 0;
    int ex = 0;
    rom[0] = 20'h00201; rom[1] = 20'h00201;
    paso = 1'b0;
    launch(6'd2);
    for (int k = 1; k <= 11; k++) begin
      if (k >= 2 && (busy !== 1'b1 || instruccion[9] !== 1'b0 || instruccion[0] !== 1'b0 || ejecutadas !== 6'd0)) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("FAIL paso_wait got %0d bad cycles exp 0", bad); else passed++;
    paso = 1'b1;
    @(negedge clk);
    paso = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (instruccion[0] === 1'b1) ex++;
      @(negedge clk);
    end
    checks++;
    if (ex != 1 || ejecutadas !== 6'd1) $display("FAIL paso_single got execs=%0d ej=%0d exp 1/1", ex, ejecutadas); else passed++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ejecutadas !== 6'd1) $display("FAIL paso_abort got done=%b ej=%0d exp 1/1", done, ejecutadas); else passed++;
    paso = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; paso = 1'b1; num_instr = '0;
    for (int i = 0; i < 32; i++) rom[i] = 20'h0;
    test_reset;
    test_program;
    test_halt;
    test_zero_len;
    test_abort;
    test_reset_midrun;
`ifdef SECUENCIADOR_PASO_EN
    test_paso;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/secuenciador_isa.md
Name: secuenciador_isa

Overview:
- Multi-cycle controller that sequences the 20-bit instruction datapath (register bank -> ALU -> RAM).
- Fetches instructions from a synchronous instruction ROM and presents each one to the datapath for exactly one execute cycle.
- Datapath write enables are asserted only during that execute cycle, never during fetch or decode.
- Runs a program of num_instr words from address 0 using a start/done handshake; supports halt word and abort.

Parameters:
PC_W, 5, width of program counter and ROM address (max 2^PC_W instructions)
HALT_WORD, 20'hFFFFF, instruction word that terminates the program; it is never executed

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin program run; sampled only in IDLE
abort  input  1  synchronous abort of a running program
num_instr  input  PC_W+1  program length in words; sampled on accepted start
imem_addr  output  PC_W  instruction ROM address
imem_data  input  20  ROM read data, valid the cycle after imem_addr is driven
instruccion  output  20  instruction to datapath: [19:15] DL1, [14:10] DL2, [9] we, [8:6] AluOp, [5:1] dir, [0] WE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of run (normal, halt or abort)
halted  output  1  sticky: last run ended on HALT_WORD; cleared on next accepted start
pc  output  PC_W  address of the instruction currently in flight
ejecutadas  output  PC_W+1  count of instructions executed in current/last run

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, pc=0, imem_addr=0, instruccion=0, busy=0, done=0, halted=0, ejecutadas=0. Reset asserted mid-run aborts immediately; datapath write bits go to 0 on the same edge.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - On start=1, latch num_instr and clear pc, ejecutadas and halted.
  - If num_instr==0 -> DONE; else -> FETCH.
- FETCH: imem_addr=pc -> DECODE.
- DECODE:
  - Register imem_data into instr_q.
  - If imem_data==HALT_WORD: set halted -> DONE.
  - Else -> EXEC.
- EXEC:
  - instruccion = instr_q with bits [9] and [0] as fetched, for this one cycle only.
  - ejecutadas+1; pc+1.
  - If pc+1 == latched num_instr -> DONE; else -> FETCH.
- Outside EXEC:
  - instruccion[9] and [0] forced to 0.
  - Remaining fields hold instr_q so datapath read addresses are stable through DECODE->EXEC.
- DONE: done=1 for one cycle -> IDLE.
- Throughput: 3 cycles per executed instruction. Latency from start to done = 3*N+2 cycles for N instructions with no halt.
- abort=1 in FETCH/DECODE/EXEC:
  - -> DONE next edge; the EXEC-cycle write, if any, is suppressed.
  - ejecutadas not incremented for the aborted instruction.
  - abort has priority over the halt check and the pc increment.
  - abort in IDLE or DONE has no effect.
- start while busy=1: ignored, not queued.
- pc wrap: not possible. num_instr is limited to 2^PC_W; pc stops at num_instr-1.
- Width: ejecutadas saturates at num_instr by construction; no overflow logic needed.

Optional Feature:
SECUENCIADOR_PASO_EN:
- With macro defined: adds input port `paso` (1 bit).
  - In DECODE (non-halt), the FSM waits until paso=1 before entering EXEC.
  - instruccion read fields are held and write bits stay 0 while waiting.
  - abort is still honoured during the wait.
- Without macro: no `paso` port; DECODE always advances to EXEC after one cycle.

Test Plan:
1. ROM={20'h0A2C3, 20'h11045, 20'h08040}, num_instr=3, pulse start:
   - 3 EXEC cycles at cycles 3, 6 and 9 after start.
   - instruccion in each EXEC equals the ROM word.
   - done pulses at cycle 11; ejecutadas=3; halted=0.
2. ROM[1]=20'hFFFFF, num_instr=5:
   - Only word 0 is executed.
   - halted=1, ejecutadas=1, done pulses; instruccion[9]=instruccion[0]=0 throughout.
3. num_instr=0, start:
   - No FETCH; done pulses 2 cycles after start; busy high for exactly 1 cycle.
4. Abort:
   - num_instr=4; assert abort in the EXEC cycle of word 2: no write bits asserted that cycle, ejecutadas=2, done next cycle.
   - Assert start during the run: ignored.
5. Reset mid-run:
   - rst_n=0 during DECODE: all outputs read as their reset values on the next edge.
   - A subsequent start runs from pc=0.
6. With SECUENCIADOR_PASO_EN, paso held 0 for 10 cycles:
   - FSM stays in DECODE with write bits 0.
   - One-cycle paso=1 yields exactly one EXEC.
